// File: rtl/jump_pkg.sv
// Shared opcode classes, PC source encoding and sizing rule for the
// decode-stage jump/return-stack unit.
package jump_pkg;

    typedef enum logic [1:0] {
        PC_PLUS1,
        PC_OFFSET,
        PC_CONST,
        PC_STACK
    } pc_src_e;

    localparam logic [2:0] OP_COND = 3'b110;
    localparam logic [1:0] FN_BZ   = 2'b00;
    localparam logic [1:0] FN_BNZ  = 2'b01;
    localparam logic [1:0] FN_BC   = 2'b10;
    localparam logic [1:0] FN_BNC  = 2'b11;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [4:0] OP_JSB  = 5'b11101;
    localparam logic [5:0] OP_RET  = 6'b111100;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jump_stack_unit_return_stack.sv
// Return-address stack with full/empty tracking and overflow policy.
// JUMP_STACK_WRAP_EN selects circular overwrite instead of dropping pushes.
module return_stack
    import jump_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [PC_W-1:0]           push_data,
    output logic [PC_W-1:0]           top,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   cnt,
    output logic                      ovf,
    output logic                      unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign cnt   = cnt_q;
    assign top   = mem_q[sp_q - 1'b1];
    assign ovf   = push & full;
    assign unf   = pop & empty;
    assign do_pop = pop & ~empty;

    // When full, sp_q points at the oldest entry, so a wrapping push
    // overwrites exactly that slot.
`ifdef JUMP_STACK_WRAP_EN
    assign do_push = push;
`else
    assign do_push = push & ~full;
`endif

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            sp_d = sp_q + 1'b1;
            if (!full) cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            sp_d  = sp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[sp_q] <= push_data;
    end

endmodule

// File: rtl/jump_stack_unit.sv
// Decode-stage branch/jump/return resolver with internal return stack.
// Build with JUMP_STACK_WRAP_EN for a circular (overwrite-oldest) stack.
module jump_stack_unit
    import jump_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              opcode,
    input  logic                    valid,
    input  logic                    stall,
    input  logic                    z_out,
    input  logic                    c_out,
    input  logic [PC_W-1:0]         pc_plus1,
    input  logic [PC_W-1:0]         offset_target,
    input  logic [PC_W-1:0]         const_target,
    input  logic                    err_clr,
    output logic [PC_W-1:0]         next_pc,
    output logic                    sel_PC_src_plus1,
    output logic                    sel_PC_src_offset,
    output logic                    sel_PC_src_const,
    output logic                    sel_PC_src_stack,
    output logic                    flush_PR1,
    output logic                    stack_empty,
    output logic                    stack_full,
    output logic [cnt_w(DEPTH)-1:0] stack_cnt,
    output logic                    ovf_err,
    output logic                    unf_err
);

    logic        shadow_q, shadow_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        elig, is_cond, is_jmp, is_jsb, is_ret, cond_ok;
    logic        push, pop, ovf_s, unf_s;
    logic [PC_W-1:0] top;
    pc_src_e     src;

    // Reset gating keeps the outputs on the PLUS1 decode while rst_n is low.
    assign elig    = rst_n & valid & ~stall & ~shadow_q;
    assign is_cond = (opcode[5:3] == OP_COND);
    assign is_jmp  = (opcode[5:2] == OP_JMP);
    assign is_jsb  = (opcode[5:1] == OP_JSB);
    assign is_ret  = (opcode == OP_RET);

    always_comb begin
        cond_ok = 1'b0;
        unique case (opcode[2:1])
            FN_BZ:   cond_ok = z_out;
            FN_BNZ:  cond_ok = ~z_out;
            FN_BC:   cond_ok = c_out;
            FN_BNC:  cond_ok = ~c_out;
            default: cond_ok = 1'b0;
        endcase
    end

    assign push = elig & is_jsb;
    assign pop  = elig & is_ret;

    always_comb begin
        src = PC_PLUS1;
        if (elig) begin
            if (is_cond && cond_ok)        src = PC_OFFSET;
            else if (is_jmp)               src = PC_CONST;
            else if (is_ret && !stack_empty) src = PC_STACK;
        end
    end

    always_comb begin
        next_pc = pc_plus1;
        unique case (src)
            PC_OFFSET: next_pc = offset_target;
            PC_CONST:  next_pc = const_target;
            PC_STACK:  next_pc = top;
            default:   next_pc = pc_plus1;
        endcase
    end

    assign sel_PC_src_plus1  = (src == PC_PLUS1);
    assign sel_PC_src_offset = (src == PC_OFFSET);
    assign sel_PC_src_const  = (src == PC_CONST);
    assign sel_PC_src_stack  = (src == PC_STACK);
    assign flush_PR1         = (src != PC_PLUS1);

    assign shadow_d = stall ? shadow_q : flush_PR1;
    assign ovf_d    = ovf_s | (ovf_q & ~err_clr);
    assign unf_d    = unf_s | (unf_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

    return_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (top),
        .empty     (stack_empty),
        .full      (stack_full),
        .cnt       (stack_cnt),
        .ovf       (ovf_s),
        .unf       (unf_s)
    );

endmodule

// File: doc/jump_stack_unit.md
# jump_stack_unit

- Parametrised successor to the decode-stage jump controller.
- Resolves conditional branches (BZ/BNZ/BC/BNC), unconditional jumps (JMP/JSB) and RET from the decode-stage opcode.
- Owns the return-address stack internally, with configurable depth, overflow/underflow detection and a self-generated flush-shadow.
- Drives PC-source selection, the resolved next PC and the PR1 flush.

## Interface
Parameters:
- PC_W, 12, program-counter width in bits.
- DEPTH, 8, return-stack entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  decode-stage opcode.
- valid  in  1  opcode holds a real instruction.
- stall  in  1  pipeline hold.
- z_out  in  1  zero flag.
- c_out  in  1  carry flag.
- pc_plus1  in  PC_W  return address for JSB.
- offset_target  in  PC_W  branch target.
- const_target  in  PC_W  absolute jump target.
- err_clr  in  1  clears the sticky error flags.
- next_pc  out  PC_W  resolved next PC.
- sel_PC_src_plus1, sel_PC_src_offset, sel_PC_src_const, sel_PC_src_stack  out  1 each  one-hot PC source.
- flush_PR1  out  1  squash the PR1 instruction.
- stack_empty, stack_full  out  1 each  stack status.
- stack_cnt  out  $clog2(DEPTH)+1  live entries.
- ovf_err, unf_err  out  1 each  sticky overflow/underflow flags.

## Operation
**Decode** (opcode classes from the shared defines):
- COND, opcode[5:3]: function field opcode[2:1] selects the condition BZ→z_out, BNZ→~z_out, BC→c_out, BNC→~c_out.
- JMP/JSB, opcode[5:2]; JSB is identified by opcode[5:1].
- RET, full 6-bit match.

**Eligibility:** an instruction is eligible when valid=1, stall=0 and shadow=0.

**Taken actions:**
- Condition true → OFFSET source, flush_PR1=1.
- JMP → CONST source, flush_PR1=1.
- JSB → CONST source, flush_PR1=1, push pc_plus1.
- RET with stack non-empty → STACK source, next_pc=top, flush_PR1=1, pop.
- Otherwise → PLUS1 source, next_pc=pc_plus1, flush_PR1=0.

**Shadow flag:**
- Set on the edge after any redirect.
- Cleared on the next non-stalled edge.
- While set, the opcode is ignored (it is the flushed slot).
- Held unchanged while stall=1.

**Stall:** stall=1 forces PLUS1, flush_PR1=0, and blocks every state change.

**RET on empty stack:**
- No pop, no redirect (PLUS1).
- unf_err sets on that edge.

**JSB on full stack:** behaviour depends on the Configuration macro.

**Error flags:**
- ovf_err and unf_err are sticky until err_clr.
- If err_clr and a new error occur on the same edge, the new error wins (flag ends set).

**Exclusivity:** push and pop never coincide, since only one opcode is evaluated per cycle.

## Timing
- Decisions are combinational from the inputs in the same cycle: next_pc, the selects and flush_PR1 have zero latency.
- Stack, counter, shadow and error-flag updates take effect on the rising edge.
- A pushed value is visible to a RET evaluated in the following cycle (one-cycle push-to-pop).
- Reset values:
  - stack_cnt=0, stack_empty=1, stack_full=0.
  - shadow=0, ovf_err=0, unf_err=0.
  - Stack contents are don't-care.
- Outputs settle to the PLUS1 decode of the current inputs during reset.
- Reset asserted mid-operation discards all stack contents immediately (asynchronous).

## Configuration
Macro: JUMP_STACK_WRAP_EN.
- **Defined:** circular stack.
  - JSB when full overwrites the oldest entry; stack_cnt stays at DEPTH.
  - The jump is still taken.
  - ovf_err sets.
- **Undefined:** JSB when full still takes the jump, but the push is dropped (contents unchanged); ovf_err sets.
- Underflow behaviour is identical in both builds.

## Structure
- **Package jump_pkg:**
  - pc_src_e enum {PC_PLUS1, PC_OFFSET, PC_CONST, PC_STACK}.
  - Opcode-class and function-code constants, mirroring the shared defines.
  - The localparam rule for the counter width.
- **Sub-module return_stack, parametrised PC_W/DEPTH:**
  - Holds the storage array, top pointer, count and full/empty flags.
  - Implements the wrap/drop policy.
  - Exposes push, pop, push_data, top, empty, full, cnt, ovf and unf strobes.
- **Top level:** decode, shadow flag, one-hot source select, next_pc mux and sticky error flags.

## Test plan
1. Reset, then BZ with z_out=1 and offset_target=0x040 → sel_PC_src_offset=1, next_pc=0x040, flush_PR1=1. A BZ presented in the next cycle is ignored (shadow).
2. JSB with const_target=0x100, pc_plus1=0x011, then RET two cycles later (after the shadow clears) → next_pc=0x011, sel_PC_src_stack=1, stack_cnt returns 1→0.
3. Nested calls: push 0x001..0x008 (DEPTH=8) → stack_full=1. Eight RETs return 0x008..0x001 in LIFO order, then stack_empty=1.
4. RET on empty → PLUS1 selected, flush_PR1=0, unf_err=1 held until err_clr pulse.
5. Ninth JSB on full stack:
   - With JUMP_STACK_WRAP_EN: the top becomes the new address, eight RETs return new,0x008..0x002, ovf_err=1.
   - Without: the jump is taken, the first RET returns 0x008, ovf_err=1.
6. stall=1 during JSB → no push, flush_PR1=0. After stall drops, the push occurs. rst_n pulsed mid-sequence → stack_cnt=0 immediately.
